dsp_mac_seq: RTL and testbench

//   Sequencer for one multiply-accumulate vector operation on the DSP datapath.

---
 rtl/dsp_mac_seq_if.sv | 27 ++
 rtl/dsp_mac_seq.sv | 138 +++++++++++++
 tb/tb_dsp_mac_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_seq_if.sv
// Control bus between a MAC sequencer and its environment: operation request,
// operand stream handshake, datapath enables/OPMODE and status.
interface dsp_mac_seq_if #(
   parameter int LEN_W = 8
);
   logic             i_start;
   logic [LEN_W-1:0] i_len;
   logic             i_abort;
   logic             i_in_valid;
   logic             o_in_ready;
   logic             o_ce_ab;
   logic             o_ce_m;
   logic             o_ce_p;
   logic [7:0]       o_opmode;
   logic             o_busy;
   logic             o_done;

   modport master (
      output i_start, i_len, i_abort, i_in_valid,
      input  o_in_ready, o_ce_ab, o_ce_m, o_ce_p, o_opmode, o_busy, o_done
   );

   modport slave (
      input  i_start, i_len, i_abort, i_in_valid,
      output o_in_ready, o_ce_ab, o_ce_m, o_ce_p, o_opmode, o_busy, o_done
   );
endinterface

// File: rtl/dsp_mac_seq.sv
// Control-only sequencer for one multiply-accumulate vector operation on an
// A/B -> M -> P pipelined DSP datapath.
module dsp_mac_seq #(
   parameter int         LEN_W   = 8,
   parameter logic [7:0] OP_LOAD = 8'h01,
   parameter logic [7:0] OP_ACC  = 8'h09,
   parameter logic [7:0] OP_ZERO = 8'h00
) (
   input logic          clk,
   input logic          rst,
   dsp_mac_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_cnt;
   logic             r_v1;
   logic             r_v2;
   logic             r_f1;
   logic             r_f2;
   logic             r_first_pend;

   logic             w_in_ready;
   logic             w_acc;
   logic             w_first;
   logic             w_ce_p;
   logic [7:0]       w_opmode;
   logic [LEN_W-1:0] w_len;

   assign w_len = bus.i_len;

   // Handshake decode and the tag marking the first pair of an operation.
   always_comb begin
      w_in_ready = (r_state == S_RUN);
      w_acc      = bus.i_in_valid & w_in_ready;
      w_first    = w_acc & r_first_pend;
   end

   // P-stage enable and OPMODE; CLR owns P for its single cycle.
   always_comb begin
      w_ce_p   = r_v2 | (r_state == S_CLR);
      w_opmode = 8'h00;
      if (r_state == S_CLR) begin
         w_opmode = OP_ZERO;
      end else if (r_v2) begin
         w_opmode = r_f2 ? OP_LOAD : OP_ACC;
      end else begin
         w_opmode = 8'h00;
      end
   end

   assign bus.o_in_ready = w_in_ready;
   assign bus.o_ce_ab    = w_acc;
   assign bus.o_ce_m     = r_v1;
   assign bus.o_ce_p     = w_ce_p;
   assign bus.o_opmode   = w_opmode;
   assign bus.o_busy     = (r_state != S_IDLE);
   assign bus.o_done     = (r_state == S_DONE);

   // Operation FSM plus the valid/first shadow of the A/B -> M -> P pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_f1         <= 1'b0;
         r_f2         <= 1'b0;
         r_first_pend <= 1'b0;
      end else if (bus.i_abort) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_f1         <= 1'b0;
         r_f2         <= 1'b0;
         r_first_pend <= 1'b0;
      end else begin
         r_v1 <= w_acc;
         r_f1 <= w_first;
         r_v2 <= r_v1;
         r_f2 <= r_f1;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  if (w_len == '0) begin
                     r_state <= S_CLR;
                  end else begin
                     r_cnt        <= w_len;
                     r_first_pend <= 1'b1;
                     r_state      <= S_RUN;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CLR: begin
               r_state <= S_DONE;
            end
            S_RUN: begin
               if (w_acc) begin
                  r_cnt        <= r_cnt - LEN_W'(1);
                  r_first_pend <= 1'b0;
                  if (r_cnt == LEN_W'(1)) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state <= S_RUN;
                  end
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_DRAIN: begin
               // Last product is entering P exactly when v2 is set and v1 is empty.
               if (r_v2 && !r_v1) begin
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_DRAIN;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Self-checking bench for dsp_mac_seq: a behavioural datapath driven by the
// DUT enables plus a cycle-level reference of accepts, enables and done timing.
module tb_dsp_mac_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [7:0]  a_in = 8'd0;
   logic [7:0]  b_in = 8'd0;
   logic [7:0]  a_vec [256];
   logic [7:0]  b_vec [256];
   logic [7:0]  dp_a = 8'd0;
   logic [7:0]  dp_b = 8'd0;
   logic [15:0] dp_m = 16'd0;
   logic [31:0] dp_p = 32'd0;
   bit          acc_h [0:511];

   always #5 clk = ~clk;

   dsp_mac_seq_if #(.LEN_W(8)) bus ();

   dsp_mac_seq #(.LEN_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Datapath stand-in: registers move only under the sequencer's enables.
   always @(posedge clk) begin
      if (bus.o_ce_ab) begin
         dp_a <= a_in;
         dp_b <= b_in;
      end
      if (bus.o_ce_m) dp_m <= dp_a * dp_b;
      if (bus.o_ce_p) begin
         case (bus.o_opmode)
            8'h01:   dp_p <= {16'd0, dp_m};
            8'h09:   dp_p <= dp_p + {16'd0, dp_m};
            8'h00:   dp_p <= 32'd0;
            default: dp_p <= 32'hDEAD_BEEF;
         endcase
      end
   end

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},     0, 32'(bus.o_busy),     32'd0);
      chk({tag, "_in_ready"}, 0, 32'(bus.o_in_ready), 32'd0);
      chk({tag, "_ce_ab"},    0, 32'(bus.o_ce_ab),    32'd0);
      chk({tag, "_ce_m"},     0, 32'(bus.o_ce_m),     32'd0);
      chk({tag, "_ce_p"},     0, 32'(bus.o_ce_p),     32'd0);
      chk({tag, "_opmode"},   0, 32'(bus.o_opmode),   32'd0);
      chk({tag, "_done"},     0, 32'(bus.o_done),     32'd0);
   endtask

   // mode 0: in_valid always 1; mode 1: pattern bits then 1; mode 2: random.
   task automatic drive_valid(input int c, input int mode, input logic [31:0] pat);
      logic v;
      if (mode == 0)             v = 1'b1;
      else if (mode == 1)        v = (c <= 32) ? pat[c-1] : 1'b1;
      else                       v = ($urandom_range(0, 3) != 0);
      bus.i_in_valid = v;
   endtask

   // Runs one operation from a negedge, checking every cycle until one idle cycle after done.
   task automatic run_op(input int len, input int mode, input logic [31:0] pat, input int poke_len);
      int          c;
      int          nacc;
      int          first_c;
      int          done_c;
      logic [31:0] exp_sum;
      logic        exp_ready;
      logic        pm1;
      logic        pm2;
      logic        exp_cep;
      logic [7:0]  exp_op;
      exp_sum = 32'd0;
      for (int i = 0; i < len; i++) begin
         a_vec[i] = 8'($urandom);
         b_vec[i] = 8'($urandom);
         exp_sum  = exp_sum + 32'(a_vec[i]) * 32'(b_vec[i]);
      end
      for (int i = 0; i < 512; i++) acc_h[i] = 1'b0;
      bus.i_start = 1'b1;
      bus.i_len   = len[7:0];
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      nacc    = 0;
      first_c = -1;
      done_c  = (len == 0) ? 2 : -1;
      c       = 1;
      drive_valid(c, mode, pat);
      a_in = a_vec[nacc];
      b_in = b_vec[nacc];
      forever begin
         @(negedge clk);
         exp_ready = (nacc < len);
         acc_h[c]  = exp_ready & bus.i_in_valid;
         if (acc_h[c] && first_c < 0) first_c = c;
         pm1     = acc_h[c-1];
         pm2     = (c >= 2) ? acc_h[c-2] : 1'b0;
         exp_cep = pm2 | ((len == 0) && (c == 1));
         if ((len == 0) && (c == 1)) exp_op = 8'h00;
         else if (pm2)               exp_op = ((c - 2) == first_c) ? 8'h01 : 8'h09;
         else                        exp_op = 8'h00;
         chk("in_ready", c, 32'(bus.o_in_ready), 32'(exp_ready));
         chk("ce_ab",    c, 32'(bus.o_ce_ab),    32'(acc_h[c]));
         chk("ce_m",     c, 32'(bus.o_ce_m),     32'(pm1));
         chk("ce_p",     c, 32'(bus.o_ce_p),     32'(exp_cep));
         chk("opmode",   c, 32'(bus.o_opmode),   32'(exp_op));
         chk("done",     c, 32'(bus.o_done),     32'((done_c > 0) && (c == done_c)));
         chk("busy",     c, 32'(bus.o_busy),     32'(!((done_c > 0) && (c > done_c))));
         if ((done_c > 0) && (c == done_c)) chk("p_sum", c, dp_p, exp_sum);
         if (acc_h[c]) begin
            nacc++;
            if (nacc == len) done_c = c + 3;
         end
         if ((done_c > 0) && (c == done_c + 1)) break;
         if (c >= 400) begin
            chk("timeout", c, 32'd1, 32'd0);
            break;
         end
         @(posedge clk);
         #1;
         c++;
         bus.i_start = (poke_len >= 0) && (c == 2);
         if (bus.i_start) bus.i_len = poke_len[7:0];
         drive_valid(c, mode, pat);
         a_in = a_vec[nacc];
         b_in = b_vec[nacc];
      end
      bus.i_in_valid = 1'b0;
      bus.i_start    = 1'b0;
   endtask

   initial begin
      bus.i_start    = 1'b0;
      bus.i_len      = 8'd0;
      bus.i_abort    = 1'b0;
      bus.i_in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk_idle_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(4, 0, 32'd0, -1);
      run_op(3, 1, 32'b101001, -1);
      run_op(0, 0, 32'd0, -1);
      run_op(1, 0, 32'd0, -1);
      run_op(1, 2, 32'd0, -1);

      // Abort after two accepts of a len=5 operation.
      bus.i_start = 1'b1;
      bus.i_len   = 8'd5;
      @(posedge clk);
      #1;
      bus.i_start    = 1'b0;
      bus.i_in_valid = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.i_in_valid = 1'b0;
      bus.i_abort    = 1'b1;
      @(posedge clk);
      #1;
      bus.i_abort = 1'b0;
      @(negedge clk);
      chk_idle_outputs("abort");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", i, 32'(bus.o_done), 32'd0);
      end
      bus.i_abort = 1'b1;
      bus.i_start = 1'b1;
      bus.i_len   = 8'd3;
      @(posedge clk);
      #1;
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      @(negedge clk);
      chk("abort_start_idle", 0, 32'(bus.o_busy), 32'd0);
      run_op(2, 0, 32'd0, -1);

      // Asynchronous reset asserted off-edge in the middle of RUN.
      bus.i_start = 1'b1;
      bus.i_len   = 8'd6;
      @(posedge clk);
      #1;
      bus.i_start    = 1'b0;
      bus.i_in_valid = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("rst_mid_in_ready", 0, 32'(bus.o_in_ready), 32'd0);
      chk("rst_mid_busy", 0, 32'(bus.o_busy), 32'd0);
      chk("rst_mid_ce_m", 0, 32'(bus.o_ce_m), 32'd0);
      chk("rst_mid_ce_p", 0, 32'(bus.o_ce_p), 32'd0);
      bus.i_in_valid = 1'b0;
      bus.i_start    = 1'b1;
      bus.i_len      = 8'd3;
      @(negedge clk);
      chk_idle_outputs("rst_hold");
      @(posedge clk);
      #3 rst = 1'b0;
      bus.i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_after_busy", i, 32'(bus.o_busy), 32'd0);
         chk("rst_after_done", i, 32'(bus.o_done), 32'd0);
      end

      // start with a different len while busy must not disturb the operation.
      run_op(3, 2, 32'd0, 7);
      for (int k = 0; k < 3; k++) begin
         run_op(int'($urandom_range(1, 12)), 2, 32'd0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
